// File: rtl/basemul_seq_pkg.sv
// Shared types and constants for the basemul job sequencer.
package basemul_seq_pkg;

    localparam int PW        = 32;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CAL,
        DRAIN,
        FIN
    } state_e;

    // Number of coefficient pairs in one polynomial.
    function automatic int np_of(input int depth);
        return 1 << (depth - 1);
    endfunction

endpackage

// File: rtl/basemul_seq_cnt.sv
// Saturating pair counter with synchronous clear, last and terminal flags.
module basemul_seq_cnt #(
    parameter int W     = 8,
    parameter int LIMIT = 128
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o   = (cnt_q == W'(LIMIT));
    assign last_o = (cnt_q == W'(LIMIT - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/basemul_seq.sv
// Sequencer feeding polynomials A and B into the basemul core and draining results.
module basemul_seq
    import basemul_seq_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             finish,
    output logic             error,
    output logic             src_en,
    output logic [DEPTH-1:0] src_addr,
    input  logic [PW-1:0]    src_rdata,
    output logic             core_set,
    output logic             core_readin_a,
    output logic             core_readin_b,
    input  logic             core_readin_a_ok,
    input  logic             core_readin_b_ok,
    output logic [PW-1:0]    core_din,
    output logic [DEPTH-1:0] core_in_index,
    output logic             core_full_in_a,
    output logic             core_full_in_b,
    output logic             core_cal_en,
    output logic             core_readout,
    input  logic             core_done,
    input  logic [PW-1:0]    core_dout,
    input  logic [DEPTH-1:0] core_out_index,
    output logic             res_we,
    output logic [DEPTH-2:0] res_addr,
    output logic [PW-1:0]    res_wdata
);

    localparam int NP = np_of(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    state_e           state_q, state_d;
    logic [DEPTH-1:0] rd_cnt, wr_cnt;
    logic             rd_last, rd_tc, wr_last, wr_tc;
    logic             ld_a, ld_b, ld_ok, cnt_clr, wr_en, tmo_hit;
    logic             rd_a_q, rd_b_q, last_q, full_a_q, full_b_q;
    logic             err_q, err_d;
    logic [DEPTH-1:0] idx_q;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             unused_bits;

    // Assert asynchronously, release two clocks after reset rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    assign ld_a    = (state_q == LOAD_A);
    assign ld_b    = (state_q == LOAD_B);
    assign ld_ok   = (ld_a && core_readin_a_ok) || (ld_b && core_readin_b_ok);
    assign src_en  = ld_ok && !rd_tc;
    assign cnt_clr = (state_q != state_d);
    assign wr_en   = (state_q == DRAIN) && core_done;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    basemul_seq_cnt #(.W(DEPTH), .LIMIT(NP)) u_ld_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (src_en),
        .cnt_o  (rd_cnt),
        .last_o (rd_last),
        .tc_o   (rd_tc)
    );

    basemul_seq_cnt #(.W(DEPTH), .LIMIT(NP)) u_dr_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (wr_en),
        .cnt_o  (wr_cnt),
        .last_o (wr_last),
        .tc_o   (wr_tc)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        tmo_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                    err_d   = 1'b0;
                end
            end
            LOAD_A: if (full_a_q) state_d = LOAD_B;
            LOAD_B: if (full_b_q) state_d = CAL;
            CAL: begin
                tmo_d = tmo_q + 1'b1;
                if (core_done) begin
                    state_d = DRAIN;
                end else if (tmo_hit) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end
            end
            DRAIN: if (wr_en && wr_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            rd_a_q   <= 1'b0;
            rd_b_q   <= 1'b0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            rd_a_q   <= src_en && ld_a;
            rd_b_q   <= src_en && ld_b;
            last_q   <= src_en && rd_last;
            idx_q    <= src_en ? {rd_cnt[DEPTH-2:0], 1'b0} : '0;
            full_a_q <= last_q && rd_a_q;
            full_b_q <= last_q && rd_b_q;
        end
    end

    assign busy     = (state_q != IDLE) && (state_q != FIN);
    assign core_set = busy;
    assign finish   = (state_q == FIN);
    assign error    = err_q;
    assign src_addr = (ld_a || ld_b) ? {ld_b, rd_cnt[DEPTH-2:0]} : '0;

    // Read data arrives the cycle after src_en, aligned with the valid flag.
    assign core_readin_a  = rd_a_q;
    assign core_readin_b  = rd_b_q;
    assign core_din       = (rd_a_q || rd_b_q) ? src_rdata : '0;
    assign core_in_index  = idx_q;
    assign core_full_in_a = full_a_q;
    assign core_full_in_b = full_b_q;
    assign core_cal_en    = (state_q == CAL);
    assign core_readout   = (state_q == DRAIN);

    assign res_we    = wr_en;
    assign res_addr  = wr_en ? core_out_index[DEPTH-1:1] : '0;
    assign res_wdata = wr_en ? core_dout : '0;

    assign unused_bits = ^{rd_cnt[DEPTH-1], wr_cnt, wr_tc, core_out_index[0]};

endmodule

// File: tb/tb_basemul_seq.sv
// Directed/randomized bench for basemul_seq against a job-level model.
module tb_basemul_seq;

    localparam int DEPTH = 8;
    localparam int NP    = 128;
    localparam int TMO   = 64;

    logic             clk = 1'b0;
    logic             reset, start;
    logic             busy, finish, error, src_en;
    logic [DEPTH-1:0] src_addr;
    logic [31:0]      src_rdata = '0;
    logic             core_set, core_readin_a, core_readin_b;
    logic             core_readin_a_ok, core_readin_b_ok;
    logic [31:0]      core_din;
    logic [DEPTH-1:0] core_in_index;
    logic             core_full_in_a, core_full_in_b, core_cal_en, core_readout;
    logic             core_done;
    logic [31:0]      core_dout;
    logic [DEPTH-1:0] core_out_index;
    logic             res_we;
    logic [DEPTH-2:0] res_addr;
    logic [31:0]      res_wdata;

    int checks = 0;
    int errors = 0;

    basemul_seq #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .busy             (busy),
        .finish           (finish),
        .error            (error),
        .src_en           (src_en),
        .src_addr         (src_addr),
        .src_rdata        (src_rdata),
        .core_set         (core_set),
        .core_readin_a    (core_readin_a),
        .core_readin_b    (core_readin_b),
        .core_readin_a_ok (core_readin_a_ok),
        .core_readin_b_ok (core_readin_b_ok),
        .core_din         (core_din),
        .core_in_index    (core_in_index),
        .core_full_in_a   (core_full_in_a),
        .core_full_in_b   (core_full_in_b),
        .core_cal_en      (core_cal_en),
        .core_readout     (core_readout),
        .core_done        (core_done),
        .core_dout        (core_dout),
        .core_out_index   (core_out_index),
        .res_we           (res_we),
        .res_addr         (res_addr),
        .res_wdata        (res_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pair_of(input int a);
        return {16'(2 * a + 1), 16'(2 * a)};
    endfunction

    // Source memory: pair at address a holds coefficients {2a+1, 2a}.
    always @(posedge clk) begin
        if (src_en) src_rdata <= pair_of(int'(src_addr));
    end

    function automatic logic [127:0] outs();
        return {busy, finish, error, src_en, src_addr, core_set,
                core_readin_a, core_readin_b, core_din, core_in_index,
                core_full_in_a, core_full_in_b, core_cal_en, core_readout,
                res_we, res_addr, res_wdata};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic core_idle();
        start            = 1'b0;
        core_readin_a_ok = 1'b1;
        core_readin_b_ok = 1'b1;
        core_done        = 1'b0;
        core_dout        = '0;
        core_out_index   = '0;
    endtask

    task automatic run_job(input int stall_at, input int done_dly,
                           input bit rand_ok, input bit spam, input int rst_at);
        int cyc = 0, exp_rd = 0, ndl = 0, nfa = 0, nfb = 0, nfin = 0;
        int ncal = 0, nwr = 0, stall_left = 5, a, j, t;
        int last_a = -9, last_b = -9, last_cal = -9, last_wr = -9, fin_cyc = -9;
        int perm[NP];
        logic [31:0] dvals[NP];
        logic [31:0] res_mem[NP];
        int pend[$];
        bit seen_fin = 0, aborted = 0, stalled;
        logic err_fin = 1'b0;
        logic exp_err;
        exp_err = (done_dly < 0);
        for (int i = 0; i < NP; i++) begin
            perm[i]    = i;
            dvals[i]   = $urandom;
            res_mem[i] = '0;
        end
        for (int i = NP - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        @(negedge clk);
        start = 1'b1;
        while (!seen_fin && !aborted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start   = spam && busy && ($urandom_range(0, 7) == 0);
            stalled = (stall_at >= 0 && exp_rd == stall_at && stall_left > 0);
            if (stalled) stall_left--;
            core_readin_a_ok = !stalled && (!rand_ok || $urandom_range(0, 3) != 0);
            core_readin_b_ok = !rand_ok || $urandom_range(0, 3) != 0;
            core_done = core_readout ||
                        (core_cal_en && done_dly >= 0 && ncal >= done_dly);
            if (core_done && nwr < NP) begin
                core_out_index = 8'(2 * perm[nwr]);
                core_dout      = dvals[perm[nwr]];
            end
            #1;
            if (cyc == 1) begin
                chk("busy_on_start", busy, 1);
                chk("err_cleared", error, 0);
            end
            if (core_cal_en) begin ncal++; last_cal = cyc; end
            if (stalled) begin
                chk("stall_no_rd", src_en, 0);
                chk("stall_addr", src_addr, stall_at);
            end
            if (src_en) begin
                chk("src_addr", src_addr, exp_rd);
                chk("rd_ok", src_addr[7] ? core_readin_b_ok : core_readin_a_ok, 1);
                pend.push_back(exp_rd);
                exp_rd++;
            end
            if (core_readin_a || core_readin_b) begin
                if (pend.size() == 0) begin
                    chk("spurious_readin", 1, 0);
                end else begin
                    a = pend.pop_front();
                    ndl++;
                    chk("readin_sel", {core_readin_a, core_readin_b},
                        (a < NP) ? 2'b10 : 2'b01);
                    chk("in_index", core_in_index, 2 * (a % NP));
                    chk("din", core_din, pair_of(a));
                    if (a == NP - 1) last_a = cyc;
                    if (a == 2 * NP - 1) last_b = cyc;
                end
            end
            if (core_full_in_a) begin nfa++; chk("full_a_t", cyc - last_a, 1); end
            if (core_full_in_b) begin nfb++; chk("full_b_t", cyc - last_b, 1); end
            if (res_we) begin
                if (nwr < NP) begin
                    chk("res_addr", res_addr, perm[nwr]);
                    res_mem[res_addr] = res_wdata;
                end
                nwr++;
                last_wr = cyc;
            end
            if (finish) begin
                nfin++;
                fin_cyc  = cyc;
                err_fin  = error;
                seen_fin = 1;
                chk("busy_at_fin", busy, 0);
            end
            if (rst_at >= 0 && src_en && int'(src_addr) == rst_at) begin
                reset = 1'b0;
                core_idle();
                #1;
                chk("rst_outs", outs(), '0);
                aborted = 1;
            end
        end
        if (aborted) return;
        chk("fin_cnt", nfin, 1);
        chk("err_at_fin", err_fin, exp_err);
        chk("reads", exp_rd, 2 * NP);
        chk("delivered", ndl, 2 * NP);
        chk("full_a_cnt", nfa, 1);
        chk("full_b_cnt", nfb, 1);
        if (exp_err) begin
            chk("cal_cycles", ncal, TMO);
            chk("no_writes", nwr, 0);
            chk("fin_after_cal", fin_cyc - last_cal, 1);
        end else begin
            chk("writes", nwr, NP);
            chk("fin_after_wr", fin_cyc - last_wr, 1);
            for (int i = 0; i < NP; i++) chk("res_mem", res_mem[i], dvals[i]);
        end
        core_idle();
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle_busy", busy, 0);
        end
        chk("idle_err", error, exp_err);
    endtask

    initial begin
        reset = 1'b0;
        core_idle();
        @(negedge clk);
        #1;
        chk("reset_outs", outs(), '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run_job(-1, 20, 0, 0, -1);
        run_job(40, 20, 0, 0, -1);
        run_job(-1, -1, 0, 0, -1);
        run_job(-1, 20, 1, 1, -1);
        run_job(-1, $urandom_range(0, 30), 1, 0, NP + 10);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_hold", outs(), '0);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run_job(-1, 5, 0, 1, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
